seg_display_arbiter: RTL

- Shares the single 4-digit seven-segment display between two BCD sources, A and B, for example a counter value and a status/message word.
- Uses a req/gnt handshake with a minimum on-screen hold time and round-robin fairness.
- Drives the 16-bit packed-BCD word (digit 3 in [15:12], digit 0 in [3:0]) plus a blank flag into the existing multiplexed segment driver.

---
 rtl/seg_display_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit BCD display between sources A and B, with minimum hold time.
// Optional ownership timeout/preemption is built only when SEG_ARB_TIMEOUT_EN is defined.
module seg_display_arbiter #(
    parameter int HOLD_CYCLES     = 1000,
    parameter int CNT_W           = 20,
    parameter int MAX_HOLD_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic [15:0] bcd_a,
    input  logic        req_b,
    input  logic [15:0] bcd_b,
    output logic        gnt_a,
    output logic        gnt_b,
    output logic [15:0] bcd_out,
    output logic        blank_o,
    output logic        hold_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN_A = 2'd1;
    localparam logic [1:0] S_OWN_B = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);

    logic [1:0]       r_state;
    logic             r_ptr_b;
    logic             r_gnt_a;
    logic             r_gnt_b;
    logic             r_blank;
    logic             r_hold_done;
    logic [15:0]      r_bcd;
    logic [CNT_W-1:0] r_cnt;

    logic             w_own_a;
    logic             w_req_own;
    logic             w_req_oth;
    logic [15:0]      w_bcd_own;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_release;
    logic             w_preempt;
    logic             w_switch;

    assign w_own_a   = (r_state == S_OWN_A);
    assign w_req_own = w_own_a ? req_a : req_b;
    assign w_req_oth = w_own_a ? req_b : req_a;
    assign w_bcd_own = w_own_a ? bcd_a : bcd_b;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // r_hold_done is never set in IDLE, so these only fire while a side owns the display
    assign w_release = r_hold_done & ~w_req_own;
    assign w_switch  = w_req_oth & (w_release | w_preempt);

`ifdef SEG_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD_CYCLES);

    logic [CNT_W-1:0] r_tcnt;

    // Counts owned cycles including the current one, so preemption lands after exactly MAX_HOLD_CYCLES
    assign w_preempt = (r_state != S_IDLE) && (r_tcnt >= MAX_CNT - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else if (r_state == S_IDLE || w_switch || w_release) begin
            r_tcnt <= '0;
        end else if (r_tcnt < MAX_CNT) begin
            r_tcnt <= r_tcnt + CNT_W'(1);
        end
    end
`else
    assign w_preempt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ptr_b     <= 1'b0;
            r_gnt_a     <= 1'b0;
            r_gnt_b     <= 1'b0;
            r_blank     <= 1'b1;
            r_hold_done <= 1'b0;
            r_bcd       <= 16'h0000;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_OWN_A, S_OWN_B: begin
                    if (w_switch) begin
                        // Direct hand-over: display word stays frozen until the new owner's first capture
                        r_state     <= w_own_a ? S_OWN_B : S_OWN_A;
                        r_gnt_a     <= ~w_own_a;
                        r_gnt_b     <= w_own_a;
                        r_ptr_b     <= ~w_own_a;
                        r_hold_done <= 1'b0;
                        r_cnt       <= '0;
                    end else if (w_release) begin
                        r_state     <= S_IDLE;
                        r_gnt_a     <= 1'b0;
                        r_gnt_b     <= 1'b0;
                        r_blank     <= 1'b1;
                        r_hold_done <= 1'b0;
                        r_bcd       <= 16'h0000;
                        r_cnt       <= '0;
                    end else begin
                        if (r_cnt < HOLD_CNT) begin
                            r_cnt <= w_cnt_inc;
                        end
                        r_hold_done <= r_hold_done | (w_cnt_inc >= HOLD_CNT);
                        if (w_req_own) begin
                            r_bcd <= w_bcd_own;
                        end
                    end
                end
                default: begin
                    if (req_a && (!req_b || !r_ptr_b)) begin
                        r_state     <= S_OWN_A;
                        r_gnt_a     <= 1'b1;
                        r_blank     <= 1'b0;
                        r_ptr_b     <= 1'b1;
                        r_hold_done <= 1'b0;
                        r_cnt       <= '0;
                    end else if (req_b) begin
                        r_state     <= S_OWN_B;
                        r_gnt_b     <= 1'b1;
                        r_blank     <= 1'b0;
                        r_ptr_b     <= 1'b0;
                        r_hold_done <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
            endcase
        end
    end

    assign gnt_a     = r_gnt_a;
    assign gnt_b     = r_gnt_b;
    assign bcd_out   = r_bcd;
    assign blank_o   = r_blank;
    assign hold_done = r_hold_done;

endmodule
